// File: rtl/mem_arbiter.sv
// Unified-memory arbiter between the fetch and memory pipeline stages.
// Data has priority, with bounded fetch starvation, cancel and timeout.
module mem_arbiter #(
   parameter int TIMEOUT    = 16,
   parameter int MAX_STARVE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   input  logic        fetch_cancel,
   output logic        fetch_done,
   output logic [15:0] fetch_rdata,
   output logic        fetch_stall,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [15:0] data_addr,
   input  logic [15:0] data_wdata,
   output logic        data_done,
   output logic [15:0] data_rdata,
   output logic        data_stall,
   input  logic        halt,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   output logic        err
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int SW = $clog2(MAX_STARVE + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] S_MAX  = SW'(MAX_STARVE);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_F,
      BUSY_D
   } state_t;

   state_t        state;
   logic          cancel_q;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] tcnt;

   logic f_cand;
   logic grant_f;
   logic grant_d;
   logic f_end;
   logic d_end;
   logic expired;

   assign f_cand  = fetch_req & ~halt;
   assign grant_f = f_cand & (~data_req | (starve_cnt == S_MAX));
   assign grant_d = data_req & ~grant_f;

   assign f_end   = (state == BUSY_F) & mem_done;
   assign d_end   = (state == BUSY_D) & mem_done;
   assign expired = (state != IDLE) & ~mem_done & (tcnt == T_LAST);

   // A cancel raised now or earlier in this access swallows the result.
   assign fetch_done  = f_end & fetch_req & ~cancel_q & ~fetch_cancel;
   assign fetch_rdata = fetch_done ? mem_rdata : 16'h0000;
   assign fetch_stall = fetch_req & ~fetch_done;

   assign data_done  = d_end & data_req;
   assign data_rdata = (data_done & ~mem_wr) ? mem_rdata : 16'h0000;
   assign data_stall = data_req & ~data_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_en     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= 16'h0000;
         mem_wdata  <= 16'h0000;
         err        <= 1'b0;
         cancel_q   <= 1'b0;
         starve_cnt <= '0;
         tcnt       <= '0;
      end else begin
         mem_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_f) begin
                  state      <= BUSY_F;
                  mem_en     <= 1'b1;
                  mem_wr     <= 1'b0;
                  mem_addr   <= fetch_addr;
                  mem_wdata  <= 16'h0000;
                  tcnt       <= '0;
                  cancel_q   <= 1'b0;
                  starve_cnt <= '0;
               end else if (grant_d) begin
                  state     <= BUSY_D;
                  mem_en    <= 1'b1;
                  mem_wr    <= data_wr;
                  mem_addr  <= data_addr;
                  mem_wdata <= data_wdata;
                  tcnt      <= '0;
                  if (f_cand && starve_cnt != S_MAX) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end
            end
            BUSY_F: begin
               if (mem_done) begin
                  state    <= IDLE;
                  cancel_q <= 1'b0;
               end else if (expired) begin
                  state    <= IDLE;
                  err      <= 1'b1;
                  cancel_q <= 1'b0;
               end else begin
                  tcnt <= tcnt + 1'b1;
                  if (fetch_cancel) begin
                     cancel_q <= 1'b1;
                  end
               end
            end
            BUSY_D: begin
               if (mem_done) begin
                  state <= IDLE;
               end else if (expired) begin
                  state <= IDLE;
                  err   <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change 1 time unit after the rising edge; outputs checked mid-cycle.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_cancel;
   logic        fetch_done;
   logic [15:0] fetch_rdata;
   logic        fetch_stall;
   logic        data_req;
   logic        data_wr;
   logic [15:0] data_addr;
   logic [15:0] data_wdata;
   logic        data_done;
   logic [15:0] data_rdata;
   logic        data_stall;
   logic        halt;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   mem_arbiter #(.TIMEOUT(16), .MAX_STARVE(4)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_cancel(fetch_cancel), .fetch_done(fetch_done),
      .fetch_rdata(fetch_rdata), .fetch_stall(fetch_stall),
      .data_req(data_req), .data_wr(data_wr),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_done(data_done), .data_rdata(data_rdata),
      .data_stall(data_stall), .halt(halt),
      .mem_en(mem_en), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_en(input string tag);
      int n = 0;
      while (mem_en !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk(tag, 32'(mem_en), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic exp_f;
      int   en_seen;
      rst = 1'b1;
      fetch_req = 1'b0; fetch_addr = 16'h0; fetch_cancel = 1'b0;
      data_req = 1'b0; data_wr = 1'b0; data_addr = 16'h0;
      data_wdata = 16'h0; halt = 1'b0; mem_rdata = 16'h0;
      mem_done = 1'b0;
      step();
      step();
      chk("rst mem_en", 32'(mem_en), 0);
      chk("rst mem_addr", 32'(mem_addr), 0);
      chk("rst err", 32'(err), 0);
      chk("rst stalls", 32'({fetch_stall, data_stall}), 0);
      rst = 1'b0;

      // single load
      data_req = 1'b1; data_addr = 16'h0040; data_wr = 1'b0;
      #1 chk("load stall", 32'(data_stall), 1);
      wait_en("load en");
      chk("load addr", 32'(mem_addr), 'h0040);
      chk("load wr", 32'(mem_wr), 0);
      chk("load done early", 32'(data_done), 0);
      step();
      chk("load en pulse", 32'(mem_en), 0);
      mem_done = 1'b1; mem_rdata = 16'hBEEF;
      #1 chk("load done", 32'(data_done), 1);
      chk("load rdata", 32'(data_rdata), 'hBEEF);
      chk("load stall off", 32'(data_stall), 0);
      step();
      mem_done = 1'b0; data_req = 1'b0;
      #1 chk("load idle done", 32'(data_done), 0);
      chk("load idle en", 32'(mem_en), 0);

      // starvation: D,D,D,D,F repeated
      fetch_req = 1'b1; fetch_addr = 16'h0300;
      data_req = 1'b1; data_addr = 16'h0050; data_wr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp_f = (i == 4 || i == 9);
         wait_en($sformatf("arb en %0d", i));
         chk($sformatf("arb addr %0d", i), 32'(mem_addr),
             exp_f ? 'h0300 : 'h0050);
         mem_done = 1'b1; mem_rdata = 16'(i + 1);
         #1;
         chk($sformatf("arb done %0d", i),
             32'({fetch_done, data_done}), exp_f ? 2 : 1);
         step();
         mem_done = 1'b0;
      end
      fetch_req = 1'b0; data_req = 1'b0;
      step();

      // fetch cancel
      fetch_req = 1'b1; fetch_addr = 16'h0100;
      wait_en("can en");
      chk("can addr", 32'(mem_addr), 'h0100);
      fetch_cancel = 1'b1;
      step();
      fetch_cancel = 1'b0; fetch_addr = 16'h0200;
      step();
      step();
      mem_done = 1'b1; mem_rdata = 16'hAAAA;
      #1 chk("can no done", 32'(fetch_done), 0);
      chk("can stall", 32'(fetch_stall), 1);
      step();
      mem_done = 1'b0;
      #1 chk("can idle en", 32'(mem_en), 0);
      wait_en("refetch en");
      chk("refetch addr", 32'(mem_addr), 'h0200);
      mem_done = 1'b1; mem_rdata = 16'h5555;
      #1 chk("refetch done", 32'(fetch_done), 1);
      chk("refetch rdata", 32'(fetch_rdata), 'h5555);
      step();
      mem_done = 1'b0; fetch_req = 1'b0;
      step();

      // halt blocks fetch, not stores
      halt = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0400;
      en_seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (mem_en !== 1'b0 || fetch_stall !== 1'b1) en_seen++;
      end
      chk("halt no grant", 32'(en_seen), 0);
      data_req = 1'b1; data_wr = 1'b1;
      data_addr = 16'h0010; data_wdata = 16'h1234;
      wait_en("store en");
      chk("store addr", 32'(mem_addr), 'h0010);
      chk("store wr", 32'(mem_wr), 1);
      chk("store wdata", 32'(mem_wdata), 'h1234);
      mem_done = 1'b1; mem_rdata = 16'hFFFF;
      #1 chk("store done", 32'(data_done), 1);
      chk("store rdata", 32'(data_rdata), 0);
      step();
      mem_done = 1'b0; data_req = 1'b0; data_wr = 1'b0;
      halt = 1'b0; fetch_req = 1'b0;
      step();

      // timeout
      data_req = 1'b1; data_addr = 16'h0060;
      wait_en("to en");
      en_seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (data_done !== 1'b0 || mem_en !== 1'b0) en_seen++;
      end
      chk("to busy quiet", 32'(en_seen), 0);
      chk("to err early", 32'(err), 0);
      step();
      chk("to err", 32'(err), 1);
      chk("to idle en", 32'(mem_en), 0);
      chk("to no done", 32'(data_done), 0);
      step();
      chk("to regrant", 32'(mem_en), 1);
      chk("to regrant addr", 32'(mem_addr), 'h0060);
      mem_done = 1'b1; mem_rdata = 16'h0BAD;
      #1 chk("to regrant done", 32'(data_done), 1);
      step();
      mem_done = 1'b0;
      data_addr = 16'h0070;
      step();
      chk("err sticky", 32'(err), 1);

      // async reset mid-access
      wait_en("rst en");
      #2 rst = 1'b1;
      #1 chk("arst en", 32'(mem_en), 0);
      chk("arst addr", 32'(mem_addr), 0);
      chk("arst err", 32'(err), 0);
      chk("arst done", 32'(data_done), 0);
      step();
      rst = 1'b0; data_req = 1'b0;
      mem_done = 1'b1; mem_rdata = 16'h7777;
      #1 chk("late done", 32'({fetch_done, data_done}), 0);
      step();
      mem_done = 1'b0;
      #1 chk("late no grant", 32'(mem_en), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 16-bit pipelined processor.
- Sequences each access through a small FSM and returns completion/stall signals to both pipeline stages.
- Provides starvation protection for fetch, fetch-cancel on branch redirect, halt gating and a backend-timeout watchdog.

Parameters:
- TIMEOUT, 16: max cycles in a busy state without mem_done before abort; counter width is clog2(TIMEOUT)+1.
- MAX_STARVE, 4: consecutive data grants issued while fetch waits before fetch is forced to win.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- fetch_req  in  1  fetch access request, level; held with fetch_addr stable until fetch_done or cancel
- fetch_addr  in  16  instruction address
- fetch_cancel  in  1  branch redirect; discard the in-flight fetch result
- fetch_done  out  1  one-cycle completion pulse; fetch_rdata valid
- fetch_rdata  out  16  instruction word
- fetch_stall  out  1  fetch_req & ~fetch_done
- data_req  in  1  data access request, level; held stable until data_done
- data_wr  in  1  1 = store, 0 = load
- data_addr  in  16  data address
- data_wdata  in  16  store data
- data_done  out  1  one-cycle completion pulse
- data_rdata  out  16  load data
- data_stall  out  1  data_req & ~data_done
- halt  in  1  halt reached memory stage; block new fetch grants
- mem_en  out  1  one-cycle access strobe to memory
- mem_wr  out  1  write enable, held during access
- mem_addr  out  16  held during access
- mem_wdata  out  16  held during access
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_done  in  1  access complete
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, any time including mid-access):
  - state IDLE; mem_en, mem_wr, mem_addr, mem_wdata, err, cancel flag, starve_cnt and timeout counter all 0.
  - The in-flight access is abandoned; no done pulse is issued for it.
- FSM states: IDLE, BUSY_F, BUSY_D.
- IDLE grant rule: a candidate is fetch_req & ~halt, and/or data_req.
  - Data wins, except when both request and starve_cnt==MAX_STARVE; then fetch wins.
  - On grant: next state BUSY_x. mem_en=1 for exactly the first BUSY cycle (registered). mem_addr, mem_wr (0 for fetch) and mem_wdata are registered from the winner and held until return to IDLE.
  - starve_cnt: on a data grant while fetch_req & ~halt, increment, saturating at MAX_STARVE. On a fetch grant, clear to 0.
- BUSY_x:
  - mem_done accepted in any BUSY cycle, including the mem_en cycle.
  - On mem_done: x_done=1 combinationally that cycle, x_rdata=mem_rdata (16'h0000 for stores); next state IDLE.
  - Minimum turnaround: request seen in IDLE at cycle T -> done at T+1. Requester drops or changes req the cycle after done; back-to-back grants therefore have one IDLE cycle between them.
- Cancel:
  - fetch_cancel in BUSY_F sets the cancel flag.
  - fetch_cancel coincident with mem_done suppresses fetch_done.
  - If the flag is set, mem_done completes the access silently: fetch_done stays 0, state goes to IDLE, flag clears.
  - fetch_cancel in IDLE or BUSY_D: no effect.
- Timeout:
  - Counter clears on grant and increments each BUSY cycle.
  - Reaching TIMEOUT without mem_done: err<=1 (sticky until rst), state IDLE, no done pulse. The requester stays stalled and is re-arbitrated.
- mem_done in IDLE: ignored.
- halt: an in-flight fetch completes normally; data requests are unaffected.
- x_stall is combinational; x_done is never asserted while the corresponding x_req is 0.

Test Plan:
- Single load: data_req=1, data_addr=16'h0040, mem_done on the cycle after mem_en with rdata=16'hBEEF -> mem_en one cycle, mem_addr=0040, mem_wr=0, data_done one pulse with data_rdata=BEEF, data_stall falls with it.
- Simultaneous requests, both held continuously -> grant order D,D,D,D,F,D… (fetch wins on the 5th grant with MAX_STARVE=4); starve_cnt clears after the fetch grant.
- Fetch in flight (addr 16'h0100), fetch_cancel pulsed before mem_done=1 three cycles later -> no fetch_done; state IDLE; the next fetch_req (addr 16'h0200) is granted normally.
- halt=1 with only fetch_req high for 10 cycles -> mem_en never asserted, fetch_stall=1. A data store (addr 16'h0010, wdata 16'h1234) still issues: mem_wr=1, mem_wdata=1234, data_done pulses.
- mem_done never returned for a data load -> err=1 after 16 BUSY cycles, state IDLE, data regranted; err stays 1 until rst.
- rst asserted asynchronously in BUSY_D -> all outputs 0 immediately; a late mem_done after reset produces no done pulse.
